// File: rtl/score_bcd2bin_pkg.sv
// Shared constants and state encoding for the BCD score to binary converter.
package score_bcd2bin_pkg;

  localparam int unsigned NDIG    = 5;
  localparam int unsigned SCORE_W = 17;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/score_bcd2bin_if.sv
// Request/result bundle between a score source and the BCD-to-binary converter.
interface score_bcd2bin_if #(
  parameter int unsigned SCORE_W = score_bcd2bin_pkg::SCORE_W
);
  logic               start;
  logic [3:0]         dig1;
  logic [3:0]         dig2;
  logic [3:0]         dig3;
  logic [3:0]         dig4;
  logic [3:0]         dig5;
  logic [SCORE_W-1:0] score_out;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, dig1, dig2, dig3, dig4, dig5,
    input  score_out, busy, done, err
  );

  modport slave (
    input  start, dig1, dig2, dig3, dig4, dig5,
    output score_out, busy, done, err
  );
endinterface

// File: rtl/score_bcd2bin_mul10_add.sv
// One Horner step: acc*10 + digit using shifts only, plus a non-BCD digit flag.
module score_bcd2bin_mul10_add
  import score_bcd2bin_pkg::*;
#(
  parameter int unsigned ACC_W = SCORE_W + 4
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [DIG_W-1:0] digit,
  output logic [ACC_W-1:0] result_c,
  output logic             invalid_c
);

  assign result_c  = (acc << 3) + (acc << 1) + ACC_W'(digit);
  assign invalid_c = (digit > DIG_W'(BCD_MAX));

endmodule

// File: rtl/score_bcd2bin.sv
// Serial BCD score to binary converter: one decimal digit folded in per clock, MSD first.
module score_bcd2bin #(
  parameter int unsigned NDIG    = score_bcd2bin_pkg::NDIG,
  parameter int unsigned SCORE_W = score_bcd2bin_pkg::SCORE_W
) (
  input logic            clk,
  input logic            rst_n,
  score_bcd2bin_if.slave bus
);
  import score_bcd2bin_pkg::state_t;
  import score_bcd2bin_pkg::IDLE;
  import score_bcd2bin_pkg::CONV;
  import score_bcd2bin_pkg::DIG_W;

  localparam int unsigned ACC_W  = SCORE_W + 4;
  localparam int unsigned DSR_W  = NDIG * DIG_W;
  localparam int unsigned STEP_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NDIG - 1);

  state_t              state;
  state_t              next_state;
  logic [STEP_W-1:0]   step,    step_d;
  logic [ACC_W-1:0]    acc,     acc_d;
  logic [DSR_W-1:0]    dig_sr,  dig_sr_d;
  logic                invalid, invalid_d;
  logic [SCORE_W-1:0]  score,   score_d;
  logic                busy,    busy_d;
  logic                done,    done_d;
  logic                err,     err_d;

  logic [ACC_W-1:0]    mul_result;
  logic                mul_invalid;
  logic                any_invalid;

  score_bcd2bin_mul10_add #(
    .ACC_W (ACC_W)
  ) u_mul10_add (
    .acc       (acc),
    .digit     (dig_sr[DSR_W-1 -: DIG_W]),
    .result_c  (mul_result),
    .invalid_c (mul_invalid)
  );

  assign any_invalid = invalid | mul_invalid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CONV;
      CONV:    if (step == LAST_STEP) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and output next values; start during CONV falls through untouched
  always_comb begin
    step_d    = step;
    acc_d     = acc;
    dig_sr_d  = dig_sr;
    invalid_d = invalid;
    score_d   = score;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = err;
    case (state)
      IDLE: begin
        if (bus.start) begin
          dig_sr_d  = DSR_W'({bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1});
          acc_d     = '0;
          step_d    = '0;
          invalid_d = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      CONV: begin
        acc_d     = mul_result;
        dig_sr_d  = dig_sr << DIG_W;
        step_d    = step + STEP_W'(1);
        invalid_d = any_invalid;
        if (step == LAST_STEP) begin
          step_d = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
          err_d  = any_invalid;
          // A bad digit leaves the previously published score in place
          if (!any_invalid) score_d = SCORE_W'(mul_result);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step    <= '0;
      acc     <= '0;
      dig_sr  <= '0;
      invalid <= 1'b0;
      score   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      step    <= step_d;
      acc     <= acc_d;
      dig_sr  <= dig_sr_d;
      invalid <= invalid_d;
      score   <= score_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  assign bus.score_out = score;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule

// File: tb/tb_score_bcd2bin.sv
// Directed self-checking bench for score_bcd2bin.
module tb_score_bcd2bin;
  import score_bcd2bin_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_bcd2bin_if #(.SCORE_W(SCORE_W)) bus ();

  score_bcd2bin #(
    .NDIG    (NDIG),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;
  int bcyc;
  bit stab;

  task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1);
    bus.dig5 = d5; bus.dig4 = d4; bus.dig3 = d3; bus.dig2 = d2; bus.dig1 = d1;
  endtask

  // Pulse start for one edge, then scramble the digit inputs
  task automatic start_conv(input logic [3:0] d5, d4, d3, d2, d1);
    @(negedge clk);
    set_digits(d5, d4, d3, d2, d1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    set_digits(4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
  endtask

  // Bounded wait for done; cycles = 0 if it never came
  task automatic wait_done(output int cycles, output int busy_cycles, output bit stable);
    logic [SCORE_W-1:0] s0;
    bit seen;
    s0 = bus.score_out;
    seen = 1'b0;
    cycles = 0;
    busy_cycles = bus.busy ? 1 : 0;
    stable = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_cycles++;
        if (bus.score_out !== s0) stable = 1'b0;
      end
    end
    if (!seen) cycles = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.score_out !== 17'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", bus.score_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_conv(4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start: got %b expected 1", bus.busy); end
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    n_cmp++; if (bus.score_out !== 17'd54321) begin n_fail++; $display("FAIL basic_score: got %0d expected 54321", bus.score_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b expected 0", bus.done); end
  endtask

  task automatic test_invalid();
    start_conv(4'd5, 4'd4, 4'hA, 4'd2, 4'd1);
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL invalid_latency: got %0d expected 5", cyc); end
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL invalid_err: got %b expected 1", bus.err); end
    n_cmp++; if (bus.score_out !== 17'd54321) begin n_fail++; $display("FAIL invalid_score_kept: got %0d expected 54321", bus.score_out); end
  endtask

  task automatic test_all9_then_zero();
    start_conv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL all9_latency: got %0d expected 5", cyc); end
    n_cmp++; if (bus.score_out !== 17'h1869F) begin n_fail++; $display("FAIL all9_score: got %0d expected 99999", bus.score_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL all9_err_cleared: got %b expected 0", bus.err); end
    n_cmp++; if (stab !== 1'b1) begin n_fail++; $display("FAIL all9_score_stable: got %b expected 1", stab); end
    start_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (bus.score_out !== 17'd0) begin n_fail++; $display("FAIL zero_score: got %0d expected 0", bus.score_out); end
    n_cmp++; if (bcyc !== 5) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 5", bcyc); end
  endtask

  task automatic test_ignore_start();
    int dones;
    start_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    @(negedge clk);
    set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 3", cyc); end
    n_cmp++; if (bus.score_out !== 17'd12345) begin n_fail++; $display("FAIL ignore_score: got %0d expected 12345", bus.score_out); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d expected 0", dones); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int dones;
    start_conv(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.score_out !== 17'd0) begin n_fail++; $display("FAIL midrst_score: got %0d expected 0", bus.score_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", bus.err); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
    rst_n = 1'b1;
    start_conv(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL midrst_next_latency: got %0d expected 5", cyc); end
    n_cmp++; if (bus.score_out !== 17'd42) begin n_fail++; $display("FAIL midrst_next_score: got %0d expected 42", bus.score_out); end
  endtask

  task automatic test_back_to_back();
    start_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (bus.score_out !== 17'd7) begin n_fail++; $display("FAIL b2b_first_score: got %0d expected 7", bus.score_out); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_in_done_cycle: got %b expected 1", bus.done); end
    set_digits(4'd0, 4'd0, 4'd1, 4'd0, 4'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    set_digits(4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_dropped: got %b expected 0", bus.done); end
    wait_done(cyc, bcyc, stab);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 5", cyc); end
    n_cmp++; if (bus.score_out !== 17'd100) begin n_fail++; $display("FAIL b2b_score: got %0d expected 100", bus.score_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_all9_then_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bcd2bin.md
SCORE_BCD2BIN -- requirements
Module: score_bcd2bin

Interface
REQ-001 Parameter NDIG, default 5, number of decimal score digits.
REQ-002 Parameter SCORE_W, default 17, binary score width; holds 99999.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to convert the digit inputs.
REQ-006 dig1..dig5  input  4 each  BCD digits; dig1 = units, dig5 = ten-thousands.
REQ-007 score_out  output  SCORE_W  last successfully converted binary score.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 err  output  1  last conversion saw a non-BCD digit (>9).

Function
REQ-011 The FSM SHALL have two states: IDLE and CONV.
REQ-012 In IDLE, start=1 at edge N SHALL capture dig1..dig5 into an internal digit shift register, clear the accumulator and err, set busy, and enter CONV with step counter = 0.
REQ-013 In CONV, each edge SHALL perform acc <= acc*10 + d, where d is the most significant unprocessed digit (dig5 first, dig1 last), then increment the step counter.
REQ-014 The multiply by 10 SHALL be implemented as (acc<<3)+(acc<<1), with no divider or generic multiplier; intermediate width SHALL be SCORE_W+4 bits, truncated to SCORE_W only at the result load.
REQ-015 At edge N+5, after the fifth step, the FSM SHALL return to IDLE, clear busy, and assert done for exactly one cycle.
REQ-016 Total latency SHALL be 5 cycles from the start edge to the done edge.
REQ-017 Any captured digit >9 SHALL set a sticky invalid flag during CONV.
REQ-018 At completion with the invalid flag set, err SHALL be 1 and score_out SHALL hold its previous value.
REQ-019 At completion with the invalid flag clear, score_out SHALL load the accumulator and err SHALL be 0.
REQ-020 start while busy=1 SHALL be ignored: no restart and no recapture.
REQ-021 start in the same cycle that done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-022 Digit inputs SHALL be sampled only at the accepted start edge; later changes do not affect the result.
REQ-023 score_out SHALL stay stable between completions and SHALL never show partial accumulator values.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, step counter 0, accumulator 0, digit register 0, score_out 0, busy 0, done 0, err 0.
REQ-025 Reset during CONV SHALL abandon the conversion with no done pulse.
REQ-026 The first start after reset release SHALL behave as a fresh conversion.

Structure
REQ-027 A shared package SHALL hold NDIG, SCORE_W, the state encoding (IDLE/CONV), and the BCD maximum constant 9.
REQ-028 The single sub-module mul10_add SHALL be combinational: acc, digit in; acc*10+digit and digit-invalid flag out.
REQ-029 All registers SHALL live in score_bcd2bin, clocked by clk and cleared asynchronously by rst_n.

Verification
REQ-030 Digits 5,4,3,2,1 (dig5..dig1), start pulse -> done 5 cycles later, score_out=54321 (0xD431), err=0.
REQ-031 All digits 9 -> score_out=99999 (0x1869F); then all digits 0 -> score_out=0, busy high for exactly 5 cycles.
REQ-032 dig3=0xA with the others valid -> done pulses, err=1, score_out keeps the prior value (54321).
REQ-033 Second start 2 cycles into a conversion with different digits -> ignored, single done, result matches the first digits.
REQ-034 rst_n low at step 3 of a conversion -> all outputs 0 immediately, no done; next start of 00042 -> score_out=42.
REQ-035 start asserted in the done cycle with digits 00100 -> back-to-back conversion, second done 5 cycles later, score_out=100.
